vga_rect_mover: RTL

Frame-synchronous motion controller for the VGA rectangle renderer. It watches the raster position, detects the start of vertical blanking once per frame, and computes a new rectangle origin that bounces between the screen edges at a switch-selected speed. New coordinates are committed only during vertical blanking, so the renderer never sees a position change mid-frame. It sits between the sync generator and the rectangle/colour stage, which consumes `x_left` and `y_bottom` as its rectangle origin.

---
 rtl/vga_rect_mover.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/vga_rect_mover.sv
// vga_rect_mover
//   Moves a rectangle origin once per video frame. It watches the raster row
//   to find the start of vertical blanking, and computes the next origin there.
//   The rectangle bounces between the screen edges. A switch selects the speed
//   and another switch pauses the motion. New coordinates are committed only
//   during blanking, so the renderer never sees the rectangle jump mid-frame.
//
// Ports
//   clk          pixel clock, rising edge
//   rst_n        asynchronous active-low reset
//   pos_h        raster column (not needed for frame timing)
//   pos_v        raster row, 0 = top line
//   SW0, SW1     speed select, asynchronous; step = {SW1,SW0} + 1
//   SW2          pause (1 = hold position), asynchronous
//   x_left       rectangle left edge
//   y_bottom     rectangle bottom edge (0 = bottom)
//   dir_x        1 = moving right, 0 = moving left
//   dir_y        1 = moving up, 0 = moving down
//   update_done  one-cycle pulse when new coordinates appear
//   bounce       one-cycle pulse with update_done when either axis hit an edge
module vga_rect_mover #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int WIDTH    = 20,
  parameter int HEIGHT   = 100,
  parameter int X_INIT   = 320,
  parameter int Y_INIT   = 240
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pos_h,
  input  logic [9:0] pos_v,
  input  logic       SW0,
  input  logic       SW1,
  input  logic       SW2,
  output logic [9:0] x_left,
  output logic [9:0] y_bottom,
  output logic       dir_x,
  output logic       dir_y,
  output logic       update_done,
  output logic       bounce
);

  localparam logic [10:0] LIM_X = 11'(H_ACTIVE - WIDTH);
  localparam logic [10:0] LIM_Y = 11'(V_ACTIVE - HEIGHT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CALC_X,
    S_CALC_Y,
    S_COMMIT
  } state_t;

  typedef struct packed {
    logic [9:0] pos;
    logic       dir;
    logic       hit;
  } axis_t;

  // One axis of bounce arithmetic, carried at 11 bits so that pos + step
  // cannot wrap before it is compared with the limit. Under hold, the
  // position and direction pass through and the edge tests are skipped.
  function automatic axis_t axis_next(input logic [9:0]  pos,
                                      input logic        dir,
                                      input logic [2:0]  step,
                                      input logic [10:0] lim,
                                      input logic        hold);
    axis_t       r;
    logic [10:0] n;
    r.pos = pos;
    r.dir = dir;
    r.hit = 1'b0;
    n     = {1'b0, pos} + {8'd0, step};
    if (!hold) begin
      if (dir) begin
        if (n >= lim) begin
          r.pos = lim[9:0];
          r.dir = 1'b0;
          r.hit = 1'b1;
        end else begin
          r.pos = n[9:0];
        end
      end else begin
        if ({1'b0, pos} <= {8'd0, step}) begin
          r.pos = 10'd0;
          r.dir = 1'b1;
          r.hit = 1'b1;
        end else begin
          r.pos = pos - {7'd0, step};
        end
      end
    end
    return r;
  endfunction

  state_t     state_q;
  logic [2:0] sw_meta_q, sw_sync_q;
  logic       in_vb_q, in_vb_prev_q;
  logic       tick;
  logic [9:0] x_left_q, y_bottom_q;
  logic       dir_x_q, dir_y_q;
  logic       update_done_q, bounce_q;
  logic [9:0] x_sh_q, y_sh_q;
  logic       dx_sh_q, dy_sh_q, bnc_sh_q;
  logic [2:0] step_q;
  logic       hold_q;
  logic [2:0] step_d;
  axis_t      x_calc_d, y_calc_d;
  logic       unused_pos_h;

  assign unused_pos_h = ^pos_h;

  // Two-flop synchronizers for the switches: {SW2, SW1, SW0}.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q <= 3'b000;
      sw_sync_q <= 3'b000;
    end else begin
      sw_meta_q <= {SW2, SW1, SW0};
      sw_sync_q <= sw_meta_q;
    end
  end

  // Rising edge of the registered blanking flag gives one tick per frame.
  // The wrap from the last blank line back to row 0 is a falling edge, so it
  // never produces a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_vb_q      <= 1'b0;
      in_vb_prev_q <= 1'b0;
    end else begin
      in_vb_q      <= ({1'b0, pos_v} >= 11'(V_ACTIVE));
      in_vb_prev_q <= in_vb_q;
    end
  end

  assign tick = in_vb_q & ~in_vb_prev_q;

  // The step and pause switches are read live in CALC_X. They are latched in
  // CALC_X so that CALC_Y applies the same setting to the y axis.
  always_comb begin
    step_d   = {1'b0, sw_sync_q[1:0]} + 3'd1;
    x_calc_d = axis_next(x_left_q, dir_x_q, step_d, LIM_X, sw_sync_q[2]);
    y_calc_d = axis_next(y_bottom_q, dir_y_q, step_q, LIM_Y, hold_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      x_left_q      <= 10'(X_INIT);
      y_bottom_q    <= 10'(Y_INIT);
      dir_x_q       <= 1'b1;
      dir_y_q       <= 1'b1;
      update_done_q <= 1'b0;
      bounce_q      <= 1'b0;
      x_sh_q        <= 10'd0;
      y_sh_q        <= 10'd0;
      dx_sh_q       <= 1'b0;
      dy_sh_q       <= 1'b0;
      bnc_sh_q      <= 1'b0;
      step_q        <= 3'd0;
      hold_q        <= 1'b0;
    end else begin
      update_done_q <= 1'b0;
      bounce_q      <= 1'b0;
      case (state_q)
        // The first tick after reset may close a partial frame, so skip it.
        S_IDLE: if (tick) state_q <= S_WAIT;
        S_WAIT: if (tick) state_q <= S_CALC_X;
        S_CALC_X: begin
          x_sh_q   <= x_calc_d.pos;
          dx_sh_q  <= x_calc_d.dir;
          bnc_sh_q <= x_calc_d.hit;
          step_q   <= step_d;
          hold_q   <= sw_sync_q[2];
          state_q  <= S_CALC_Y;
        end
        S_CALC_Y: begin
          y_sh_q   <= y_calc_d.pos;
          dy_sh_q  <= y_calc_d.dir;
          bnc_sh_q <= bnc_sh_q | y_calc_d.hit;
          state_q  <= S_COMMIT;
        end
        S_COMMIT: begin
          x_left_q      <= x_sh_q;
          y_bottom_q    <= y_sh_q;
          dir_x_q       <= dx_sh_q;
          dir_y_q       <= dy_sh_q;
          update_done_q <= 1'b1;
          bounce_q      <= bnc_sh_q;
          state_q       <= S_WAIT;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign x_left      = x_left_q;
  assign y_bottom    = y_bottom_q;
  assign dir_x       = dir_x_q;
  assign dir_y       = dir_y_q;
  assign update_done = update_done_q;
  assign bounce      = bounce_q;

endmodule
